// File: rtl/alu_status_wb.sv
// Writeback/status stage after the ALU: registers one op, owns the flags, resolves flow ops.
// Optional macro ALU_STATUS_WB_BRANCH_COUNT_EN adds a saturating taken-branch counter.
module alu_status_wb #(
  parameter int               WIDTH       = 20,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_target,
  input  logic [2:0]       in_sr,
  input  logic             trap_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wr_en,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_target,
  output logic [3:0]       status
`ifdef ALU_STATUS_WB_BRANCH_COUNT_EN
  ,
  output logic [15:0]      branch_count
`endif
);

  localparam logic [3:0] OP_TRAP   = 4'd1;
  localparam logic [3:0] OP_JMP    = 4'd2;
  localparam logic [3:0] OP_JZ     = 4'd3;
  localparam logic [3:0] OP_JS     = 4'd4;
  localparam logic [3:0] OP_JZS    = 4'd5;
  localparam logic [3:0] OP_LSR    = 4'd6;
  localparam logic [3:0] OP_XSR    = 4'd7;
  localparam logic [3:0] OP_ALU    = 4'd8;
  localparam logic [3:0] OP_ALU_NF = 4'd9;

  typedef enum logic {RUN, TRAPPED} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                  state;
  logic                    zero_f, sign_f, carry_f;
  logic                    vld_p1;
  logic [WIDTH-1:0]        result_p1;
  logic                    wr_en_p1;
  logic                    taken_p1;
  logic [WIDTH-1:0]        target_p1;

  logic                    accept;
  logic                    taken_c;
  logic                    wr_en_c;
  logic [WIDTH-1:0]        result_c;
  logic [WIDTH-1:0]        target_c;
  logic signed [WIDTH-1:0] result_s;

  assign in_ready = (state == RUN) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign result_s = in_result;

  // Stage 0: decode the incoming op against the flags as they stand before this edge
  always_comb begin
    taken_c  = 1'b0;
    wr_en_c  = 1'b0;
    result_c = '0;
    target_c = '0;
    case (in_op)
      OP_TRAP: begin
        taken_c  = 1'b1;
        target_c = TRAP_VECTOR;
      end
      OP_JMP:  taken_c = 1'b1;
      OP_JZ:   taken_c = zero_f;
      OP_JS:   taken_c = sign_f;
      OP_JZS:  taken_c = zero_f | sign_f;
      OP_ALU, OP_ALU_NF: begin
        wr_en_c  = 1'b1;
        result_c = in_result;
      end
      default: ;
    endcase
    if (taken_c && in_op != OP_TRAP)
      target_c = in_target;
  end

  // Stage 1: output register, status register and trap state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      zero_f    <= 1'b0;
      sign_f    <= 1'b0;
      carry_f   <= 1'b0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      wr_en_p1  <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
    end else begin
      if (accept) begin
        vld_p1    <= 1'b1;
        result_p1 <= result_c;
        wr_en_p1  <= wr_en_c;
        taken_p1  <= taken_c;
        target_p1 <= target_c;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (accept) begin
        case (in_op)
          OP_ALU: begin
            zero_f  <= (in_result == '0);
            sign_f  <= (result_s < 0);
            carry_f <= in_carry;
          end
          OP_LSR: {sign_f, carry_f, zero_f} <= in_sr;
          OP_XSR: {sign_f, carry_f, zero_f} <= {sign_f, carry_f, zero_f} ^ in_sr;
          default: ;
        endcase
      end

      case (state)
        RUN:     if (accept && in_op == OP_TRAP) state <= TRAPPED;
        TRAPPED: if (trap_clear) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef ALU_STATUS_WB_BRANCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      branch_count <= 16'd0;
    else if (accept && taken_c)
      branch_count <= sat_inc16(branch_count);
  end
`endif

  assign out_valid     = vld_p1;
  assign out_result    = result_p1;
  assign out_wr_en     = wr_en_p1;
  assign branch_taken  = taken_p1;
  assign branch_target = target_p1;
  assign status        = {state == TRAPPED, sign_f, carry_f, zero_f};

endmodule

// File: tb/tb_alu_status_wb.sv
// Directed self-checking bench for alu_status_wb.
module tb_alu_status_wb;

  localparam int W = 20;
  localparam logic [W-1:0] TV = 20'h00F00;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_result;
  logic         in_carry;
  logic [W-1:0] in_target;
  logic [2:0]   in_sr;
  logic         trap_clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_wr_en;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic [3:0]   status;
`ifdef ALU_STATUS_WB_BRANCH_COUNT_EN
  logic [15:0]  branch_count;
`endif

  int checks = 0;
  int errors = 0;

  alu_status_wb #(.WIDTH(W), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_carry(in_carry), .in_target(in_target),
    .in_sr(in_sr), .trap_clear(trap_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wr_en(out_wr_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .status(status)
`ifdef ALU_STATUS_WB_BRANCH_COUNT_EN
    , .branch_count(branch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] res, input logic cy,
                       input logic [W-1:0] tgt, input logic [2:0] sr);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_carry  = cy;
    in_target = tgt;
    in_sr     = sr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_result = '0; in_carry = 1'b0;
    in_target = '0; in_sr = 3'b000; trap_clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (status !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", status); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(4'd8, 20'h00000, 1'b1, '0, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_wr_en, out_result} !== {1'b1, 1'b1, 20'h00000}) begin
      errors++; $display("FAIL alu_zero_out got v%b w%b r%h want v1 w1 r00000", out_valid, out_wr_en, out_result);
    end
    checks++;
    if (status !== 4'b0011) begin errors++; $display("FAIL alu_zero_status got %b want 0011", status); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(4'd8, 20'h80001, 1'b0, '0, 3'b000);
    tick();
    drive(4'd4, 20'h0, 1'b0, 20'h00400, 3'b000);
    tick();
    checks++;
    if ({branch_taken, branch_target, out_wr_en} !== {1'b1, 20'h00400, 1'b0}) begin
      errors++; $display("FAIL js_taken got t%b a%h w%b want t1 a00400 w0", branch_taken, branch_target, out_wr_en);
    end
    checks++;
    if (status !== 4'b0100) begin errors++; $display("FAIL js_status got %b want 0100", status); end
    drive(4'd3, 20'h0, 1'b0, 20'h00123, 3'b000);
    tick();
    checks++;
    if ({out_valid, branch_taken, branch_target} !== {1'b1, 1'b0, 20'h00000}) begin
      errors++; $display("FAIL jz_not_taken got v%b t%b a%h want v1 t0 a00000", out_valid, branch_taken, branch_target);
    end
    drive(4'd5, 20'h0, 1'b0, 20'h00777, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({branch_taken, branch_target} !== {1'b1, 20'h00777}) begin
      errors++; $display("FAIL jzs_taken got t%b a%h want t1 a00777", branch_taken, branch_target);
    end
    tick();
  endtask

  task automatic test_sr_and_nop();
    drive(4'd6, 20'h0, 1'b0, '0, 3'b101);
    tick();
    checks++;
    if ({status, out_wr_en, out_valid} !== {4'b0101, 1'b0, 1'b1}) begin
      errors++; $display("FAIL lsr got s%b w%b v%b want s0101 w0 v1", status, out_wr_en, out_valid);
    end
    drive(4'd7, 20'h0, 1'b0, '0, 3'b111);
    tick();
    checks++;
    if ({status, out_wr_en} !== {4'b0010, 1'b0}) begin
      errors++; $display("FAIL xsr got s%b w%b want s0010 w0", status, out_wr_en);
    end
    drive(4'd12, 20'h55555, 1'b1, 20'h11111, 3'b111);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_wr_en, branch_taken, out_result, status} !== {1'b1, 1'b0, 1'b0, 20'h0, 4'b0010}) begin
      errors++; $display("FAIL nop_code12 got v%b w%b t%b r%h s%b want v1 w0 t0 r00000 s0010",
                         out_valid, out_wr_en, branch_taken, out_result, status);
    end
    drive(4'd9, 20'h00000, 1'b1, '0, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_wr_en, out_result, status} !== {1'b1, 20'h00000, 4'b0010}) begin
      errors++; $display("FAIL alu_nf got w%b r%h s%b want w1 r00000 s0010", out_wr_en, out_result, status);
    end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(4'd8, 20'h12345, 1'b0, '0, 3'b000);
    tick();
    drive(4'd8, 20'h00ABC, 1'b1, '0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 20'h12345}) begin
        errors++; $display("FAIL stall_hold_%0d got rdy%b v%b r%h want rdy0 v1 r12345", i, in_ready, out_valid, out_result);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_result, status} !== {1'b1, 20'h00ABC, 4'b0010}) begin
      errors++; $display("FAIL stall_next_op got v%b r%h s%b want v1 r00abc s0010", out_valid, out_result, status);
    end
    tick();
  endtask

  task automatic test_trap();
    drive(4'd1, 20'h0, 1'b0, 20'h00999, 3'b000);
    tick();
    drive(4'd8, 20'h00001, 1'b0, '0, 3'b000);
    checks++;
    if ({branch_taken, branch_target, out_wr_en, status[3]} !== {1'b1, TV, 1'b0, 1'b1}) begin
      errors++; $display("FAIL trap_out got t%b a%h w%b trap%b want t1 a%h w0 trap1",
                         branch_taken, branch_target, out_wr_en, status[3], TV);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_in_ready got %b want 0", in_ready); end
    tick();
    checks++;
    if ({in_ready, out_valid, status[3]} !== {1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL trap_drained got rdy%b v%b trap%b want rdy0 v0 trap1", in_ready, out_valid, status[3]);
    end
`ifdef ALU_STATUS_WB_BRANCH_COUNT_EN
    checks++;
    if (branch_count !== 16'd3) begin errors++; $display("FAIL branch_count got %0d want 3", branch_count); end
`endif
    in_valid = 1'b0;
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    checks++;
    if ({status[3], in_ready, out_valid} !== {1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL trap_clear got trap%b rdy%b v%b want trap0 rdy1 v0", status[3], in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_trap();
    out_ready = 1'b0;
    drive(4'd1, 20'h0, 1'b0, '0, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, status[3]} !== {1'b1, 1'b1}) begin
      errors++; $display("FAIL pre_reset_trap got v%b trap%b want v1 trap1", out_valid, status[3]);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_result, out_wr_en, branch_taken, branch_target, status} !== '0) begin
      errors++; $display("FAIL reset_mid_trap got v%b r%h w%b t%b a%h s%b want all zero",
                         out_valid, out_result, out_wr_en, branch_taken, branch_target, status);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_trap_ready got %b want 1", in_ready); end
`ifdef ALU_STATUS_WB_BRANCH_COUNT_EN
    checks++;
    if (branch_count !== 16'd0) begin errors++; $display("FAIL reset_branch_count got %0d want 0", branch_count); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_sr_and_nop();
    test_stall();
    test_trap();
    test_reset_mid_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_status_wb.md
Name: alu_status_wb

Overview:
- Writeback and status stage directly downstream of the 20-bit ALU.
- Accepts one ALU/flow op per handshake and registers the result for the register file.
- Owns the status register (zero, sign, carry, trap) and resolves the program-flow ops: trap, no-op, jumps, load status register, XOR status register.
- One-deep output pipeline register with valid/ready on both sides.

Parameters:
- WIDTH, 20, datapath width of result and jump target.
- TRAP_VECTOR, 20'h00000, branch target issued when a TRAP op is accepted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  4  0 NOP, 1 TRAP, 2 JMP, 3 JZ, 4 JS, 5 JZS, 6 LSR, 7 XSR, 8 ALU, 9 ALU_NF; 10-15 treated as NOP.
- in_result  in  WIDTH  ALU result.
- in_carry  in  1  ALU carry-out.
- in_target  in  WIDTH  jump target.
- in_sr  in  3  operand for LSR/XSR: {sign, carry, zero}.
- trap_clear  in  1  pulse that leaves trap mode.
- out_valid  out  1  output register holds an op.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  registered result.
- out_wr_en  out  1  result is to be written back.
- branch_taken  out  1  registered; redirect fetch.
- branch_target  out  WIDTH  registered redirect address.
- status  out  4  {trap, sign, carry, zero}.

Behaviour:
- Reset (rst_n=0 at clk edge): state RUN, status=0, out_valid=0, out_result=0, out_wr_en=0, branch_taken=0, branch_target=0. Applies mid-trap or mid-stall; any held output is dropped.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Latency is 1 cycle: the accepted op appears on out_* the next cycle with out_valid=1.
- out_* hold stable while out_valid && !out_ready.
- Without an accept, out_valid clears when out_ready=1.
- ALU: out_result=in_result, out_wr_en=1. Status updates at the accept edge:
  - zero = (in_result==0)
  - sign = in_result[WIDTH-1]
  - carry = in_carry
- ALU_NF: as ALU, but status is unchanged.
- JMP: branch_taken=1, branch_target=in_target.
- JZ, JS, JZS: condition uses the status value before this accept edge.
  - JZ: taken if zero.
  - JS: taken if sign.
  - JZS: taken if zero OR sign.
  - Not taken: branch_taken=0, branch_target=0.
- LSR: {sign, carry, zero} <= in_sr.
- XSR: {sign, carry, zero} <= {sign, carry, zero} ^ in_sr.
- Ops other than ALU/ALU_NF: out_wr_en=0, out_result=0. Ops other than jumps and TRAP: branch_taken=0.
- Back-to-back ops: an ALU op followed next cycle by JZ sees the updated flags; there is no hazard bubble.
- TRAP:
  - Output: out_valid=1, branch_taken=1, branch_target=TRAP_VECTOR, out_wr_en=0.
  - status.trap<=1; state RUN->TRAP.
  - In TRAP, in_ready=0 and the output still drains normally.
  - TRAP->RUN on trap_clear=1, which clears status.trap. in_ready may rise the cycle after.
  - trap_clear in RUN is ignored. trap_clear in the same cycle as a TRAP accept is ignored; the stage enters TRAP.
- NOP and codes 10-15: out_valid pulse with all flags 0, status unchanged.

Optional Feature:
- Macro: ALU_STATUS_WB_BRANCH_COUNT_EN.
- Defined:
  - Adds output branch_count (16 bits).
  - Increments on each accept that produces branch_taken=1, including TRAP.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ALU op in_result=20'h00000, in_carry=1 -> next cycle out_valid=1, out_wr_en=1, out_result=0; status=4'b0011.
- ALU op in_result=20'h80001, then JS in_target=20'h00400 on the next cycle -> JS output branch_taken=1, branch_target=20'h00400; then JZ -> branch_taken=0.
- LSR in_sr=3'b101, then XSR in_sr=3'b111 -> status 4'b0101, then 4'b0010; out_wr_en=0 both times.
- Hold out_ready=0 for 3 cycles with an ALU op 20'h12345 pending -> in_ready=0, out_result stable at 20'h12345; release -> next op accepted the same cycle.
- TRAP accepted -> branch_target=TRAP_VECTOR, status[3]=1, in_ready=0 while in_valid stays high; trap_clear pulse -> status[3]=0, in_ready=1 the following cycle.
- Assert rst_n=0 mid-TRAP with out_valid=1 -> after the edge all outputs are 0 and state is RUN; with the macro defined, branch_count=0.
